// File: rtl/hdmi_rd_scheduler_pkg.sv
// +----------------------------------------------------------------------+
// | hdmi_rd_scheduler_pkg : shared HDMI read-path types and constants    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package hdmi_rd_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_FLUSH = 3'd2,
    ST_FILL  = 3'd3,
    ST_REQ   = 3'd4,
    ST_DONE  = 3'd5
  } rd_state_t;

  // RGB565 word width, shared with the pixel FIFO and hdmi top
  localparam int unsigned C_PIX_W         = 16;
  localparam int unsigned C_BYTES_PER_PIX = C_PIX_W / 8;
  localparam int unsigned C_INFLIGHT_W    = 13;
  localparam int unsigned C_LEVEL_W       = 12;
  localparam int unsigned C_LEN_W         = 8;

  function automatic int unsigned calc_total(input int unsigned h, input int unsigned v,
                                             input int unsigned b);
    return (h * v) / b;
  endfunction

  function automatic int unsigned calc_addr_inc(input int unsigned b);
    return b * C_BYTES_PER_PIX;
  endfunction

  localparam int unsigned C_TOTAL_DEFAULT    = calc_total(1280, 1024, 64);
  localparam int unsigned C_ADDR_INC_DEFAULT = calc_addr_inc(64);

endpackage

`default_nettype wire

// File: rtl/hdmi_rd_scheduler_if.sv
// +----------------------------------------------------------------------+
// | hdmi_rd_scheduler_if : DDR3 read request bus and pixel FIFO status   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface hdmi_rd_scheduler_if #(
  parameter int ADDR_W = 28
) ();
  import hdmi_rd_scheduler_pkg::*;

  logic                 O_Rd_Req;
  logic                 I_Rd_Ack;
  logic [ADDR_W-1:0]    O_Rd_Addr;
  logic [C_LEN_W-1:0]   O_Rd_Len;
  logic                 I_Rd_Data_Valid;
  logic [C_LEVEL_W-1:0] I_Fifo_Level;
  logic                 I_Fifo_Empty;
  logic                 O_Fifo_Flush;

  modport master (
    output O_Rd_Req, O_Rd_Addr, O_Rd_Len, O_Fifo_Flush,
    input  I_Rd_Ack, I_Rd_Data_Valid, I_Fifo_Level, I_Fifo_Empty
  );

  modport slave (
    input  O_Rd_Req, O_Rd_Addr, O_Rd_Len, O_Fifo_Flush,
    output I_Rd_Ack, I_Rd_Data_Valid, I_Fifo_Level, I_Fifo_Empty
  );

endinterface

`default_nettype wire

// File: rtl/hdmi_rd_scheduler_rd_credit_cnt.sv
// +----------------------------------------------------------------------+
// | rd_credit_cnt : words requested but not yet returned, floored at 0   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rd_credit_cnt #(
  parameter int CNT_W = 13,
  parameter int INC   = 64
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              i_add,
  input  wire              i_sub,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] c_inc = CNT_W'(INC);
  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_add && i_sub) begin
      r_count <= r_count + c_inc - c_one;
    end else if (i_add) begin
      r_count <= r_count + c_inc;
    end else if (i_sub && (r_count != '0)) begin
      r_count <= r_count - c_one;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/hdmi_rd_scheduler.sv
// +----------------------------------------------------------------------+
// | hdmi_rd_scheduler : credit-throttled frame-buffer read sequencer     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module hdmi_rd_scheduler
  import hdmi_rd_scheduler_pkg::*;
#(
  parameter int              H_ActiveSize = 1280,
  parameter int              V_ActiveSize = 1024,
  parameter int              BURST_LEN    = 64,
  parameter int              FIFO_DEPTH   = 2048,
  parameter int              ADDR_W       = 28,
  parameter logic [ADDR_W-1:0] FRAME_BASE0 = 28'h000_0000,
  parameter logic [ADDR_W-1:0] FRAME_BASE1 = 28'h080_0000
) (
  input  wire                  Pixl_CLK,
  input  wire                  Rst_Posedge,
  input  wire                  I_Pre_Vsync,
  input  wire                  I_Pre_De,
  input  wire                  I_Wr_Frame_Done,
  input  wire                  I_Wr_Frame_Idx,
  hdmi_rd_scheduler_if.master  rd_if,
  output logic                 O_Rd_Frame_Idx,
  output logic                 O_Underflow
);

  localparam int unsigned C_TOTAL    = calc_total(H_ActiveSize, V_ActiveSize, BURST_LEN);
  localparam int unsigned C_ADDR_INC = calc_addr_inc(BURST_LEN);
  localparam int          C_BURST_W  = $clog2(C_TOTAL + 1);

  localparam logic [C_BURST_W-1:0] c_total      = C_BURST_W'(C_TOTAL);
  localparam logic [C_BURST_W-1:0] c_burst_one  = C_BURST_W'(1);
  localparam logic [ADDR_W-1:0]    c_addr_inc   = ADDR_W'(C_ADDR_INC);
  localparam logic [13:0]          c_credit_lim = 14'(FIFO_DEPTH - BURST_LEN);

  // A frame must fit between the two buffer bases and lines must be whole bursts
  if ((64'(C_TOTAL) * 64'(C_ADDR_INC) > (64'(FRAME_BASE1) - 64'(FRAME_BASE0))) ||
      ((H_ActiveSize % BURST_LEN) != 0)) begin : g_cfg_err
    $error("hdmi_rd_scheduler: frame does not fit buffer spacing or BURST_LEN does not divide line");
  end

  rd_state_t              r_state;
  logic                   r_vsync_d;
  logic                   r_frame_start;
  logic                   r_fs_pending;
  logic                   r_last_done_idx;
  logic                   r_seen_frame;
  logic                   r_uf_armed;
  logic                   r_underflow;
  logic                   r_rd_req;
  logic [ADDR_W-1:0]      r_rd_addr;
  logic [C_LEN_W-1:0]     r_rd_len;
  logic                   r_fifo_flush;
  logic                   r_rd_frame_idx;
  logic [C_BURST_W-1:0]   r_burst_cnt;

  logic [C_INFLIGHT_W-1:0] w_inflight;
  logic                    w_ack;
  logic                    w_credit_ok;
  logic [ADDR_W-1:0]       w_addr_next;

  assign w_ack       = (r_state == ST_REQ) && rd_if.I_Rd_Ack;
  assign w_credit_ok = ({2'b00, rd_if.I_Fifo_Level} + {1'b0, w_inflight}) <= c_credit_lim;
  assign w_addr_next = (r_rd_frame_idx ? FRAME_BASE1 : FRAME_BASE0)
                     + ADDR_W'(r_burst_cnt) * c_addr_inc;

  rd_credit_cnt #(
    .CNT_W (C_INFLIGHT_W),
    .INC   (BURST_LEN)
  ) u_credit (
    .clk     (Pixl_CLK),
    .rst     (Rst_Posedge),
    .i_add   (w_ack),
    .i_sub   (rd_if.I_Rd_Data_Valid),
    .o_count (w_inflight)
  );

  always_ff @(posedge Pixl_CLK or posedge Rst_Posedge) begin
    if (Rst_Posedge) begin
      r_vsync_d       <= 1'b0;
      r_frame_start   <= 1'b0;
      r_last_done_idx <= 1'b0;
      r_seen_frame    <= 1'b0;
      r_uf_armed      <= 1'b0;
      r_underflow     <= 1'b0;
    end else begin
      r_vsync_d     <= I_Pre_Vsync;
      r_frame_start <= I_Pre_Vsync && !r_vsync_d;
      if (I_Wr_Frame_Done) begin
        r_last_done_idx <= I_Wr_Frame_Idx;
      end
      // Underflow is only meaningful once the first full frame has been fetched
      if (r_frame_start) begin
        r_seen_frame <= 1'b1;
        if (r_seen_frame) begin
          r_uf_armed <= 1'b1;
        end
      end
      if (r_uf_armed && I_Pre_De && rd_if.I_Fifo_Empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge Pixl_CLK or posedge Rst_Posedge) begin
    if (Rst_Posedge) begin
      r_state        <= ST_IDLE;
      r_rd_req       <= 1'b0;
      r_rd_addr      <= '0;
      r_rd_len       <= C_LEN_W'(BURST_LEN);
      r_fifo_flush   <= 1'b0;
      r_rd_frame_idx <= 1'b0;
      r_burst_cnt    <= '0;
      r_fs_pending   <= 1'b0;
    end else begin
      r_fifo_flush <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_frame_start) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_inflight == '0) begin
            r_state      <= ST_FLUSH;
            r_fifo_flush <= 1'b1;
          end
        end
        ST_FLUSH: begin
          r_rd_frame_idx <= I_Wr_Frame_Done ? I_Wr_Frame_Idx : r_last_done_idx;
          r_burst_cnt    <= '0;
          r_fs_pending   <= 1'b0;
          r_state        <= ST_FILL;
        end
        ST_FILL: begin
          if (r_frame_start) begin
            r_state <= ST_DRAIN;
          end else if (r_burst_cnt == c_total) begin
            r_state <= ST_DONE;
          end else if (w_credit_ok) begin
            r_state   <= ST_REQ;
            r_rd_req  <= 1'b1;
            r_rd_addr <= w_addr_next;
          end
        end
        ST_REQ: begin
          // The request is never withdrawn; a frame start here waits for the ack
          if (rd_if.I_Rd_Ack) begin
            r_rd_req     <= 1'b0;
            r_burst_cnt  <= r_burst_cnt + c_burst_one;
            r_fs_pending <= 1'b0;
            r_state      <= (r_fs_pending || r_frame_start) ? ST_DRAIN : ST_FILL;
          end else if (r_frame_start) begin
            r_fs_pending <= 1'b1;
          end
        end
        ST_DONE: begin
          if (r_frame_start) begin
            r_state <= ST_DRAIN;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_rd_req <= 1'b0;
        end
      endcase
    end
  end

  assign rd_if.O_Rd_Req     = r_rd_req;
  assign rd_if.O_Rd_Addr    = r_rd_addr;
  assign rd_if.O_Rd_Len     = r_rd_len;
  assign rd_if.O_Fifo_Flush = r_fifo_flush;
  assign O_Rd_Frame_Idx     = r_rd_frame_idx;
  assign O_Underflow        = r_underflow;

endmodule

`default_nettype wire
